// File: rtl/ase_pkg.sv
// Shared CCI-P/ASE definitions for the TX1 write channel.
package ase_pkg;

  localparam int CCIP_DATA_WIDTH = 512;

  typedef enum logic [1:0] {
    VC_VA  = 2'b00,
    VC_VL0 = 2'b01,
    VC_VH0 = 2'b10,
    VC_VH1 = 2'b11
  } ccip_vc_t;

  typedef logic [1:0] ccip_len_t;
  typedef logic [3:0] ccip_reqtype_t;

  localparam ccip_len_t ASE_1CL         = 2'b00;
  localparam ccip_len_t ASE_2CL         = 2'b01;
  localparam ccip_len_t ASE_4CL         = 2'b11;
  localparam ccip_len_t ASE_ILLEGAL_LEN = 2'b10;

  localparam ccip_reqtype_t ASE_WRLINE_I = 4'h0;
  localparam ccip_reqtype_t ASE_WRFENCE  = 4'h4;

  typedef struct packed {
    ccip_vc_t      vc;
    logic          sop;
    ccip_len_t     len;
    ccip_reqtype_t reqtype;
    logic [41:0]   addr;
    logic [15:0]   mdata;
  } TxHdr_t;

  // Number of data beats a multi-line write occupies; the illegal
  // encoding is treated as a single line.
  function automatic logic [2:0] ase_len_to_beats(input ccip_len_t len);
    logic [2:0] beats;
    case (len)
      ASE_2CL: beats = 3'd2;
      ASE_4CL: beats = 3'd4;
      default: beats = 3'd1;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/tx1_wr_arbiter_pkg.sv
// Local types for the TX1 write arbiter.
package tx1_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB        = 2'b00,
    BURST      = 2'b01,
    FENCE_WAIT = 2'b10
  } arb_state_t;

  localparam int BEAT_W = 3;

endpackage

// File: rtl/tx1_wr_arbiter_rr.sv
// Round-robin requester picker: combinational search from a rotating
// pointer, with the pointer itself held here.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic [ID_W-1:0]    adv_id,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_grant
);

  logic [ID_W-1:0] ptr;
  int              scan_idx;

  // Pointer moves to the requester just after the one that finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      if (adv_id == ID_W'(NUM_REQ - 1)) ptr <= '0;
      else                              ptr <= adv_id + 1'b1;
    end
  end

  // First active request at or after the pointer, wrapping around.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    any_grant = 1'b0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (int'(ptr) + k) % NUM_REQ;
      if (!any_grant && req[scan_idx]) begin
        any_grant = 1'b1;
        grant_id  = ID_W'(scan_idx);
      end
    end
    if (any_grant) grant[grant_id] = 1'b1;
  end

endmodule

// File: rtl/tx1_wr_arbiter.sv
// Shares one TX1 write channel between several requesters: round-robin
// with burst lock, outstanding-write tracking and fence ordering.
module tx1_wr_arbiter
  import ase_pkg::*;
  import tx1_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 64,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1),
  parameter int ID_W            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  TxHdr_t [NUM_REQ-1:0]                    req_hdr,
  input  logic [NUM_REQ-1:0][CCIP_DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  logic                                    ch_full,
  output TxHdr_t                                  ch_hdr,
  output logic [CCIP_DATA_WIDTH-1:0]              ch_data,
  output logic                                    ch_wr_en,
  input  logic                                    wrresp_valid,
  output logic [CNT_W-1:0]                        outstanding,
  output logic [ID_W-1:0]                         grant_id,
  output logic                                    err_sticky
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  arb_state_t                 state, next_state;
  logic [ID_W-1:0]            lock_id;
  logic [BEAT_W-1:0]          beats_total;
  logic [BEAT_W-1:0]          beat_cnt;

  logic [NUM_REQ-1:0]         arb_grant;
  logic [ID_W-1:0]            arb_id;
  logic                       arb_any;
  logic [NUM_REQ-1:0]         lock_onehot;

  logic [ID_W-1:0]            sel_id;
  logic                       sel_valid;
  TxHdr_t                     sel_hdr;
  logic [CCIP_DATA_WIDTH-1:0] sel_data;
  logic [BEAT_W-1:0]          head_beats;
  logic                       room;

  logic                       accept;
  logic                       issue;
  logic                       issue_line;
  logic                       set_err;
  logic                       rr_adv;
  logic                       lock_load;
  logic                       burst_start;
  logic                       beat_step;
  logic                       resp_underflow;
  TxHdr_t                     out_hdr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .advance   (rr_adv),
    .adv_id    (sel_id),
    .grant     (arb_grant),
    .grant_id  (arb_id),
    .any_grant (arb_any)
  );

  assign sel_id         = (state == ARB) ? arb_id : lock_id;
  assign sel_valid      = req_valid[sel_id];
  assign sel_hdr        = req_hdr[sel_id];
  assign sel_data       = req_data[sel_id];
  assign head_beats     = ase_len_to_beats(sel_hdr.len);
  assign room           = (outstanding < MAX_CNT);
  assign resp_underflow = wrresp_valid && !issue_line && (outstanding == '0);

  // Decide what the selected requester may do this cycle and where the FSM goes.
  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    issue       = 1'b0;
    issue_line  = 1'b0;
    set_err     = 1'b0;
    rr_adv      = 1'b0;
    lock_load   = 1'b0;
    burst_start = 1'b0;
    beat_step   = 1'b0;
    out_hdr     = sel_hdr;
    unique case (state)
      ARB: begin
        if (arb_any) begin
          if (sel_hdr.reqtype == ASE_WRFENCE) begin
            lock_load  = 1'b1;
            next_state = FENCE_WAIT;
          end else if (!sel_hdr.sop || sel_hdr.reqtype != ASE_WRLINE_I) begin
            if (!ch_full) begin
              accept  = 1'b1;
              set_err = 1'b1;
              rr_adv  = 1'b1;
            end
          end else if (!ch_full && room) begin
            accept     = 1'b1;
            issue      = 1'b1;
            issue_line = 1'b1;
            if (sel_hdr.len == ASE_ILLEGAL_LEN) set_err = 1'b1;
            if (head_beats > 3'd1) begin
              lock_load   = 1'b1;
              burst_start = 1'b1;
              next_state  = BURST;
            end else begin
              rr_adv = 1'b1;
            end
          end
        end
      end
      BURST: begin
        out_hdr.sop = 1'b0;
        if (sel_valid && !ch_full && room) begin
          accept     = 1'b1;
          issue      = 1'b1;
          issue_line = 1'b1;
          beat_step  = 1'b1;
          if (beat_cnt + 3'd1 == beats_total) begin
            rr_adv     = 1'b1;
            next_state = ARB;
          end
        end
      end
      FENCE_WAIT: begin
        if ((outstanding == '0) && !ch_full && sel_valid) begin
          accept     = 1'b1;
          issue      = 1'b1;
          rr_adv     = 1'b1;
          next_state = ARB;
        end
      end
      default: next_state = ARB;
    endcase
  end

  // Ready goes only to the requester whose beat is taken this cycle.
  always_comb begin
    lock_onehot          = '0;
    lock_onehot[lock_id] = 1'b1;
    req_ready            = '0;
    if (accept) req_ready = (state == ARB) ? arb_grant : lock_onehot;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB;
    else        state <= next_state;
  end

  // Locked requester and burst beat bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_id     <= '0;
      beats_total <= '0;
      beat_cnt    <= '0;
    end else begin
      if (lock_load) lock_id <= sel_id;
      if (burst_start) begin
        beats_total <= head_beats;
        beat_cnt    <= 3'd1;
      end else if (beat_step) begin
        beat_cnt <= beat_cnt + 3'd1;
      end
    end
  end

  // Registered channel outputs; header/data hold when nothing is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_wr_en <= 1'b0;
      ch_hdr   <= '0;
      ch_data  <= '0;
    end else begin
      ch_wr_en <= issue;
      if (issue) begin
        ch_hdr  <= out_hdr;
        ch_data <= sel_data;
      end
    end
  end

  // In-flight line writes: issues count up, responses count down, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (issue_line && !wrresp_valid) begin
      if (outstanding != MAX_CNT) outstanding <= outstanding + 1'b1;
    end else if (!issue_line && wrresp_valid) begin
      if (outstanding != '0) outstanding <= outstanding - 1'b1;
    end
  end

  // Last accepted requester and the sticky protocol error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id   <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (accept) grant_id <= sel_id;
      if (set_err || resp_underflow) err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tx1_wr_arbiter.sv
// Randomized scoreboard bench for tx1_wr_arbiter with a rule-level model.
module tb_tx1_wr_arbiter;
  import ase_pkg::*;

  localparam int N    = 4;
  localparam int MAXO = 8;
  localparam int CW   = $clog2(MAXO + 1);
  localparam int IW   = 2;

  typedef struct packed {
    TxHdr_t                     hdr;
    logic [CCIP_DATA_WIDTH-1:0] data;
  } beat_t;

  logic                              clk = 1'b0;
  logic                              rst_n = 1'b1;
  logic [N-1:0]                      req_valid;
  TxHdr_t [N-1:0]                    req_hdr;
  logic [N-1:0][CCIP_DATA_WIDTH-1:0] req_data;
  logic [N-1:0]                      req_ready;
  logic                              ch_full;
  TxHdr_t                            ch_hdr;
  logic [CCIP_DATA_WIDTH-1:0]        ch_data;
  logic                              ch_wr_en;
  logic                              wrresp_valid;
  logic [CW-1:0]                     outstanding;
  logic [IW-1:0]                     grant_id;
  logic                              err_sticky;

  beat_t  rq[N][$];
  beat_t  exp_q[$];
  int     vectors = 0;
  int     miscompares = 0;

  int     m_rr, m_lock, m_left, m_fence, m_out, m_gid;
  bit     m_err;
  logic [N-1:0] exp_ready;
  int     len_beats[4] = '{1, 2, 1, 4};

  always #5 clk = ~clk;

  tx1_wr_arbiter #(
    .NUM_REQ         (N),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_hdr      (req_hdr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .ch_full      (ch_full),
    .ch_hdr       (ch_hdr),
    .ch_data      (ch_data),
    .ch_wr_en     (ch_wr_en),
    .wrresp_valid (wrresp_valid),
    .outstanding  (outstanding),
    .grant_id     (grant_id),
    .err_sticky   (err_sticky)
  );

  task automatic checkOutput(input string name, input logic [CCIP_DATA_WIDTH-1:0] act,
                             input logic [CCIP_DATA_WIDTH-1:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic beat_t mkBeat(input logic sop, input ccip_len_t len, input ccip_reqtype_t rt);
    beat_t b;
    b.hdr.vc      = ccip_vc_t'($urandom_range(0, 3));
    b.hdr.sop     = sop;
    b.hdr.len     = len;
    b.hdr.reqtype = rt;
    b.hdr.addr    = {10'($urandom), 32'($urandom)};
    b.hdr.mdata   = 16'($urandom);
    for (int i = 0; i < CCIP_DATA_WIDTH / 32; i++) b.data[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic addWrite(input int r, input ccip_len_t len);
    for (int i = 0; i < len_beats[len]; i++)
      rq[r].push_back(mkBeat((i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), len, ASE_WRLINE_I));
  endtask

  task automatic addFence(input int r);
    rq[r].push_back(mkBeat(1'b1, ASE_1CL, ASE_WRFENCE));
  endtask

  task automatic addRandom(input int r);
    int x;
    int l;
    x = $urandom_range(0, 99);
    if (x < 8)       addFence(r);
    else if (x < 12) rq[r].push_back(mkBeat(1'b0, ASE_1CL, ASE_WRLINE_I));
    else if (x < 16) addWrite(r, ASE_ILLEGAL_LEN);
    else begin
      l = $urandom_range(0, 2);
      addWrite(r, (l == 0) ? ASE_1CL : (l == 1) ? ASE_2CL : ASE_4CL);
    end
  endtask

  task automatic modelReset();
    m_rr = 0; m_lock = -1; m_left = 0; m_fence = -1; m_out = 0; m_gid = 0; m_err = 0;
    exp_q.delete();
    for (int r = 0; r < N; r++) rq[r].delete();
  endtask

  // One cycle of the arbitration rules, applied to the inputs just driven.
  task automatic modelStep();
    int    g;
    bit    acc, iss, line, in_burst;
    beat_t b;
    TxHdr_t h;
    g = -1; acc = 0; iss = 0; line = 0; in_burst = 0;
    if (m_fence >= 0) begin
      if (m_out == 0 && !ch_full && req_valid[m_fence]) begin
        g = m_fence; acc = 1; iss = 1; m_fence = -1; m_rr = (g + 1) % N;
      end
    end else if (m_lock >= 0) begin
      in_burst = 1;
      if (req_valid[m_lock] && !ch_full && m_out < MAXO) begin
        g = m_lock; acc = 1; iss = 1; line = 1; m_left--;
        if (m_left == 0) begin m_lock = -1; m_rr = (g + 1) % N; end
      end
    end else begin
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
      if (g >= 0) begin
        h = rq[g][0].hdr;
        if (h.reqtype == ASE_WRFENCE) begin
          m_fence = g;
        end else if (!h.sop || h.reqtype != ASE_WRLINE_I) begin
          if (!ch_full) begin acc = 1; m_err = 1; m_rr = (g + 1) % N; end
        end else if (!ch_full && m_out < MAXO) begin
          acc = 1; iss = 1; line = 1;
          if (h.len == ASE_ILLEGAL_LEN) m_err = 1;
          if (len_beats[h.len] > 1) begin m_lock = g; m_left = len_beats[h.len] - 1; end
          else m_rr = (g + 1) % N;
        end
      end
    end
    exp_ready = '0;
    if (acc) begin
      exp_ready[g] = 1'b1;
      b = rq[g].pop_front();
      m_gid = g;
      if (in_burst) b.hdr.sop = 1'b0;
      if (iss) exp_q.push_back(b);
    end
    if (line && !wrresp_valid) m_out++;
    else if (!line && wrresp_valid) begin
      if (m_out == 0) m_err = 1;
      else m_out--;
    end
  endtask

  // resp_pct < 0 forces a response regardless of the in-flight count.
  task automatic applyStimulus(input int cycles, input int valid_pct, input int full_pct,
                               input int resp_pct);
    repeat (cycles) begin
      @(negedge clk);
      for (int r = 0; r < N; r++) begin
        req_valid[r] = (rq[r].size() > 0) && (int'($urandom_range(0, 99)) < valid_pct);
        req_hdr[r]   = (rq[r].size() > 0) ? rq[r][0].hdr : '0;
        req_data[r]  = (rq[r].size() > 0) ? rq[r][0].data : '0;
      end
      ch_full      = int'($urandom_range(0, 99)) < full_pct;
      wrresp_valid = (resp_pct < 0) ? 1'b1 : ((m_out > 0) && (int'($urandom_range(0, 99)) < resp_pct));
      #1;
      modelStep();
      checkOutput("req_ready", req_ready, exp_ready);
      @(posedge clk);
      #1;
      checkOutput("outstanding", outstanding, m_out);
      checkOutput("err_sticky", err_sticky, m_err);
      checkOutput("grant_id", grant_id, m_gid);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    req_valid = '0; ch_full = 1'b0; wrresp_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_ch_wr_en", ch_wr_en, 0);
    checkOutput("rst_ch_hdr", ch_hdr, 0);
    checkOutput("rst_ch_data", ch_data, 0);
    checkOutput("rst_outstanding", outstanding, 0);
    checkOutput("rst_grant_id", grant_id, 0);
    checkOutput("rst_err_sticky", err_sticky, 0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drainAll();
    int budget;
    bit pending;
    budget = 0;
    pending = 1;
    while (pending && budget < 400) begin
      pending = (m_out > 0) || (m_fence >= 0) || (m_lock >= 0);
      for (int r = 0; r < N; r++) if (rq[r].size() > 0) pending = 1;
      if (pending) applyStimulus(1, 100, 0, 100);
      budget++;
    end
    applyStimulus(1, 0, 0, 0);
  endtask

  // Monitor: every beat the channel sees must match the oldest predicted beat.
  initial begin
    beat_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && ch_wr_en) begin
        if (exp_q.size() == 0) checkOutput("unexpected_beat", ch_wr_en, 0);
        else begin
          e = exp_q.pop_front();
          checkOutput("ch_hdr", ch_hdr, e.hdr);
          checkOutput("ch_data", ch_data, e.data);
        end
      end
    end
  end

  initial begin
    req_valid = '0; req_hdr = '0; req_data = '0; ch_full = 1'b0; wrresp_valid = 1'b0;
    modelReset();
    doReset();

    // Round-robin single lines up to the outstanding limit, then stall and recover.
    for (int r = 0; r < N; r++) repeat (3) addWrite(r, ASE_1CL);
    applyStimulus(8, 100, 0, 0);
    checkOutput("outstanding_after_8", outstanding, 8);
    applyStimulus(12, 100, 0, 100);
    drainAll();

    // 4-line burst locked against a competing requester.
    addWrite(0, ASE_4CL);
    addWrite(1, ASE_1CL);
    applyStimulus(8, 100, 0, 40);
    drainAll();

    // Channel full in the middle of a 2-line burst.
    addWrite(0, ASE_2CL);
    applyStimulus(1, 100, 0, 0);
    addWrite(1, ASE_1CL);
    applyStimulus(3, 100, 100, 0);
    applyStimulus(4, 100, 0, 0);
    drainAll();

    // Fence waits for three prior writes to complete.
    repeat (3) addWrite(0, ASE_1CL);
    applyStimulus(3, 100, 0, 0);
    addFence(2);
    applyStimulus(4, 100, 0, 0);
    checkOutput("fence_held_out", outstanding, 3);
    applyStimulus(6, 100, 0, 100);
    drainAll();

    // Illegal length and response underflow both raise the sticky error.
    doReset();
    addWrite(0, ASE_ILLEGAL_LEN);
    applyStimulus(2, 100, 0, 0);
    checkOutput("err_illegal_len", err_sticky, 1);
    drainAll();
    doReset();
    applyStimulus(1, 0, 0, -1);
    checkOutput("underflow_err", err_sticky, 1);
    checkOutput("underflow_cnt", outstanding, 0);

    // Random traffic with backpressure and responses.
    doReset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) < 40) begin
        int r;
        r = $urandom_range(0, N - 1);
        if (rq[r].size() < 6) addRandom(r);
      end
      applyStimulus(1, 75, 20, 35);
    end
    drainAll();

    // Reset in the middle of a burst, then normal operation resumes.
    addWrite(0, ASE_4CL);
    applyStimulus(2, 100, 0, 0);
    doReset();
    addWrite(1, ASE_1CL);
    applyStimulus(3, 100, 0, 0);
    drainAll();

    checkOutput("pending_beats", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
